// File: rtl/vc_demux.sv
// Virtual-channel demultiplexer: pops words from the main FIFO and routes
// each one by its class bit to the VC0 or VC1 FIFO, with backpressure.
module vc_demux (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [5:0] main_data,
    input  logic       main_empty,
    input  logic       VC0_almost_full,
    input  logic       VC1_almost_full,
    output logic       main_pop,
    output logic       VC0_push,
    output logic [5:0] VC0_data,
    output logic       VC1_push,
    output logic [5:0] VC1_data,
    output logic [2:0] state,
    output logic [7:0] cnt_VC0,
    output logic [7:0] cnt_VC1
);

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic any_af;
    logic pop_delay;
    logic to_vc0;
    logic to_vc1;

    assign any_af   = VC0_almost_full | VC1_almost_full;
    assign main_pop = (state_q == ACTIVE) & ~main_empty & ~any_af;
    assign state    = state_q;

    // pop_delay marks the cycle the popped word sits on main_data; it is
    // delivered regardless of the state the FSM has moved on to.
    assign to_vc0 = pop_delay & ~main_data[5];
    assign to_vc1 = pop_delay &  main_data[5];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET:  state_d = INIT;
            INIT:   state_d = IDLE;
            IDLE: begin
                if (!main_empty)
                    state_d = ACTIVE;
            end
            ACTIVE: begin
                if (any_af)
                    state_d = PAUSE;
                else if (main_empty)
                    state_d = IDLE;
            end
            PAUSE: begin
                if (!any_af)
                    state_d = main_empty ? IDLE : ACTIVE;
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= RESET;
            pop_delay <= 1'b0;
            VC0_push  <= 1'b0;
            VC1_push  <= 1'b0;
            VC0_data  <= 6'd0;
            VC1_data  <= 6'd0;
            cnt_VC0   <= 8'd0;
            cnt_VC1   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pop_delay <= main_pop;
            VC0_push  <= to_vc0;
            VC1_push  <= to_vc1;
            if (to_vc0)
                VC0_data <= main_data;
            if (to_vc1)
                VC1_data <= main_data;
            cnt_VC0   <= cnt_VC0 + {7'd0, to_vc0};
            cnt_VC1   <= cnt_VC1 + {7'd0, to_vc1};
        end
    end

endmodule

// File: tb/tb_vc_demux.sv
// Scoreboard bench for vc_demux: a behavioural main FIFO feeds the DUT and
// every popped word is expected on its VC exactly two cycles later.
module tb_vc_demux;

    logic       clk;
    logic       reset_L;
    logic [5:0] main_data;
    logic       main_empty;
    logic       VC0_almost_full;
    logic       VC1_almost_full;
    logic       main_pop;
    logic       VC0_push;
    logic [5:0] VC0_data;
    logic       VC1_push;
    logic [5:0] VC1_data;
    logic [2:0] state;
    logic [7:0] cnt_VC0;
    logic [7:0] cnt_VC1;

    vc_demux dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .main_data       (main_data),
        .main_empty      (main_empty),
        .VC0_almost_full (VC0_almost_full),
        .VC1_almost_full (VC1_almost_full),
        .main_pop        (main_pop),
        .VC0_push        (VC0_push),
        .VC0_data        (VC0_data),
        .VC1_push        (VC1_push),
        .VC1_data        (VC1_data),
        .state           (state),
        .cnt_VC0         (cnt_VC0),
        .cnt_VC1         (cnt_VC1)
    );

    typedef struct packed {
        logic [5:0]  d;
        logic [31:0] c;
    } exp_t;

    logic [5:0] fifo_q[$];
    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         pops  = 0;
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Main FIFO model: read data appears the cycle after the pop.
    always @(posedge clk) begin
        logic [5:0] w;
        exp_t e;
        cyc <= cyc + 1;
        if (!reset_L) begin
            sb.delete();
        end else if (main_pop && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            main_data <= w;
            pops <= pops + 1;
            e.d = w;
            e.c = cyc + 2;
            sb.push_back(e);
        end
        if (main_pop && fifo_q.size() == 0)
            main_empty <= 1'b1;
        else
            main_empty <= (fifo_q.size() == 0);
    end

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (VC0_push || VC1_push) begin
            chk("excl", {31'd0, VC0_push & VC1_push}, 32'd0);
            if (sb.size() == 0) begin
                chk("spurious_push", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("vc", {31'd0, VC1_push}, {31'd0, e.d[5]});
                chk("data", {26'd0, e.d[5] ? VC1_data : VC0_data},
                    {26'd0, e.d});
                chk("latency", cyc, e.c);
            end
        end
        if (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            chk("missing_push", cyc, e.c);
        end
    end

    task automatic add_word(input logic [5:0] w);
        fifo_q.push_back(w);
        if (w[5]) exp_cnt1 = exp_cnt1 + 8'd1;
        else      exp_cnt0 = exp_cnt0 + 8'd1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() > 0 || sb.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
        chk("cnt0", {24'd0, cnt_VC0}, {24'd0, exp_cnt0});
        chk("cnt1", {24'd0, cnt_VC1}, {24'd0, exp_cnt1});
    endtask

    task automatic wait_pop(input int budget);
        int n = 0;
        while (!main_pop && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("pop_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        repeat (3) @(negedge clk);
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p0;
        reset_L         = 1'b0;
        VC0_almost_full = 1'b0;
        VC1_almost_full = 1'b0;
        main_data       = 6'd0;
        main_empty      = 1'b1;

        // Reset release
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_outs", {4'd0, main_pop, VC0_push, VC1_push,
                         VC0_data, VC1_data, cnt_VC0, cnt_VC1}, 32'd0);
        reset_L = 1'b1;
        @(negedge clk);
        chk("state_init", {29'd0, state}, 32'd1);
        @(negedge clk);
        chk("state_idle", {29'd0, state}, 32'd2);
        chk("idle_pop", {31'd0, main_pop}, 32'd0);

        // Single word to VC0
        p0 = pops;
        add_word(6'b011010);
        drain(20);
        chk("single_pops", pops - p0, 32'd1);
        chk("single_d0", {26'd0, VC0_data}, {26'd0, 6'b011010});
        chk("single_d1", {26'd0, VC1_data}, 32'd0);

        // Mixed burst
        add_word(6'b100001);
        add_word(6'b000010);
        add_word(6'b110011);
        drain(30);
        chk("burst_d1", {26'd0, VC1_data}, {26'd0, 6'b110011});

        // Backpressure mid-burst
        for (int i = 0; i < 6; i++)
            add_word({i[0], 1'b0, i[3:0]});
        wait_pop(20);
        VC1_almost_full = 1'b1;
        @(negedge clk);
        chk("bp_pause", {29'd0, state}, 32'd4);
        chk("bp_nopop", {31'd0, main_pop}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold", {29'd0, state}, 32'd4);
        VC1_almost_full = 1'b0;
        @(negedge clk);
        chk("bp_resume", {29'd0, state}, 32'd3);
        chk("bp_pop", {31'd0, main_pop}, 32'd1);
        drain(40);
        chk("bp_idle", {29'd0, state}, 32'd2);

        // Counter wrap on VC0
        do_reset();
        for (int i = 0; i < 256; i++)
            add_word({2'b00, i[3:0]});
        drain(600);
        chk("wrap_cnt0", {24'd0, cnt_VC0}, 32'd0);

        // Reset in the cycle after a pop
        add_word(6'b001111);
        wait_pop(20);
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        chk("mid_rst_push", {30'd0, VC0_push, VC1_push}, 32'd0);
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_cnt", {16'd0, cnt_VC0, cnt_VC1}, 32'd0);
        chk("mid_rst_data", {20'd0, VC0_data, VC1_data}, 32'd0);
        @(negedge clk);
        chk("mid_rst_push2", {30'd0, VC0_push, VC1_push}, 32'd0);
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
        reset_L = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_state", {29'd0, state}, 32'd2);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vc_demux.md
VC_DEMUX -- requirements
Module: vc_demux

Interface
REQ-001 The block SHALL use a single clock and have the following ports, in this order:
  clk  input  1  rising-edge clock; the only clock.
  reset_L  input  1  reset; synchronous, active-low.
  main_data  input  6  read data from the main FIFO, valid in the cycle after main_pop; [5]=VC class, [4]=destination, [3:0]=payload.
  main_empty  input  1  main FIFO empty.
  VC0_almost_full  input  1  VC0 FIFO almost full.
  VC1_almost_full  input  1  VC1 FIFO almost full.
  main_pop  output  1  pop request to the main FIFO (combinational).
  VC0_push  output  1  push strobe to the VC0 FIFO (registered).
  VC0_data  output  6  write data to the VC0 FIFO (registered).
  VC1_push  output  1  push strobe to the VC1 FIFO (registered).
  VC1_data  output  6  write data to the VC1 FIFO (registered).
  state  output  3  current FSM state.
  cnt_VC0  output  8  count of words routed to VC0.
  cnt_VC1  output  8  count of words routed to VC1.

Function
REQ-002 The block SHALL implement an FSM with states RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3 and PAUSE=3'd4; the state output SHALL present the current state.
REQ-003 Transitions SHALL be:
  - RESET->INIT on the first edge with reset_L high.
  - INIT->IDLE unconditionally after one cycle.
  - IDLE->ACTIVE when main_empty=0.
  - ACTIVE->PAUSE when VC0_almost_full or VC1_almost_full is 1.
  - ACTIVE->IDLE when main_empty=1 and neither almost-full is set.
  - PAUSE->ACTIVE when both almost-fulls are 0 and main_empty=0.
  - PAUSE->IDLE when both almost-fulls are 0 and main_empty=1.
  - Otherwise the state SHALL hold.
REQ-004 main_pop SHALL equal (state==ACTIVE) & ~main_empty & ~VC0_almost_full & ~VC1_almost_full, evaluated combinationally.
REQ-005 An internal register pop_delay SHALL capture main_pop each cycle and be cleared by reset.
REQ-006 Routing of the popped word:
  - In a cycle where pop_delay=1, main_data SHALL be routed by bit [5]: 0 -> VC0, 1 -> VC1.
  - The selected VCx_data SHALL be loaded with main_data unmodified, and the selected VCx_push SHALL be 1 in the next cycle.
REQ-007 Latency: main_pop high in cycle N -> word on main_data in N+1 -> VCx_push=1 with VCx_data=word in N+2.
REQ-008 The VCx_push strobes:
  - Each VCx_push SHALL be a one-cycle strobe per word and SHALL be 0 whenever no word is routed to that VC.
  - VC0_push and VC1_push SHALL never both be 1 in the same cycle.
REQ-009 VCx_data SHALL hold its last value when VCx_push=0.
REQ-010 A word already in flight (pop_delay=1) SHALL be delivered even if the FSM has entered PAUSE or IDLE. System rule: each almost-full threshold leaves at least 2 free entries.
REQ-011 cnt_VC0 and cnt_VC1 SHALL each increment by 1 in the cycle the corresponding push is asserted, and SHALL wrap 8'hFF -> 8'h00.
REQ-012 Back-to-back throughput SHALL be one word per cycle while in ACTIVE with no backpressure.

Reset
REQ-013 While reset_L=0 at a clock edge, the block SHALL set:
  - state=RESET, pop_delay=0;
  - VC0_push=0, VC1_push=0;
  - VC0_data=6'd0, VC1_data=6'd0;
  - cnt_VC0=8'd0, cnt_VC1=8'd0.
REQ-014 main_pop SHALL be 0 while in RESET, INIT, IDLE or PAUSE.
REQ-015 Reset asserted mid-transfer SHALL discard any in-flight word: no push SHALL occur in the cycle after reset is sampled.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
  - Reset release: reset_L 0->1 -> state goes 0,1,2 on successive edges; all outputs 0.
  - Single word: main FIFO holds 6'b011010, no backpressure -> main_pop for 1 cycle; 2 cycles later VC0_push=1, VC0_data=6'b011010, cnt_VC0=1, VC1_push=0.
  - Mixed burst: main FIFO holds 6'b100001, 6'b000010, 6'b110011 -> pushes VC1, VC0, VC1 on consecutive cycles; cnt_VC0=1, cnt_VC1=2; no cycle with both pushes.
  - Backpressure: VC1_almost_full=1 during the burst -> next cycle state=PAUSE, main_pop=0, in-flight word still pushed; almost-full clears with data left -> ACTIVE and popping resumes.
  - Wrap: 256 words routed to VC0 -> cnt_VC0 = 8'h00 after the 256th push.
  - Reset mid-operation: reset_L=0 in the cycle after main_pop -> no push follows; counters, data and state are all 0.
